nibble_serial_adder_ctrl: RTL and testbench

Sequencer that adds two wide operands by time-multiplexing a single 4-bit ripple adder slice, one nibble per clock, LSB nibble first. It latches the operands on a start request and steps a nibble index. It feeds each nibble plus a registered carry through the slice and assembles the result. A registered result with a one-cycle done pulse is presented on completion. It sits between a host/FSM that needs multi-nibble sums and the shared 4-bit adder datapath.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 10 +
 rtl/nibble_serial_adder_ctrl_if.sv | 25 ++
 rtl/nibble_serial_adder_ctrl_slice.sv | 21 ++
 rtl/nibble_serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
package nibble_serial_adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Host-side bus of the nibble-serial adder: request/operands in, status/result out.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
    output start, a_in, b_in, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Purely combinational 4-bit ripple-carry adder slice shared by every nibble step.
module four_bit_adder_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer adding two NIBBLES-wide operands one nibble per clock through a single
// shared 4-bit slice, LSB first, with a registered result and one-cycle done pulse.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               c_out_q, c_out_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  four_bit_adder_slice u_slice (
    .a  (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b  (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    unique case (state_q)
      // DONE behaves like IDLE for acceptance, giving back-to-back operation.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.c_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        work_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = work_d;
          c_out_d = slice_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.busy  = (state_q == ST_ADD);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed and random additions against an arithmetic reference.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus_if ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one addition; returns during the done cycle so the caller may chain another.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit mid_start);
    logic [W:0] ref_full;
    int edges;
    int busy_cycles;
    bit seen;
    ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    bus_if.start = 1'b1;
    bus_if.a_in  = a;
    bus_if.b_in  = b;
    bus_if.c_in  = ci;
    step();
    bus_if.start = 1'b0;
    bus_if.a_in  = W'($urandom);
    bus_if.b_in  = W'($urandom);
    bus_if.c_in  = 1'($urandom);
    edges = 0;
    busy_cycles = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.busy && bus_if.done) chk("busy_done_overlap", 1, 0);
      if (bus_if.done) begin
        seen = 1;
        break;
      end
      if (bus_if.busy) busy_cycles++;
      if (mid_start && edges == 1) begin
        bus_if.start = 1'b1;
        bus_if.a_in  = 16'hAAAA;
      end else if (mid_start && edges == 2) begin
        bus_if.start = 1'b0;
      end
      step();
      edges++;
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", edges, NIBBLES);
    chk("busy_cycles", busy_cycles, NIBBLES);
    chk("sum", 32'(bus_if.sum), 32'(ref_full[W-1:0]));
    chk("c_out", 32'(bus_if.c_out), 32'(ref_full[W]));
    exp_sum  = ref_full[W-1:0];
    exp_cout = ref_full[W];
    $display("op a=0x%04h b=0x%04h ci=%0d -> sum=0x%04h c_out=%0d (%0d cycles)",
             a, b, ci, bus_if.sum, bus_if.c_out, edges);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_done"}, 32'(bus_if.done), 0);
      chk({tag, "_busy"}, 32'(bus_if.busy), 0);
      chk({tag, "_sum"}, 32'(bus_if.sum), 32'(exp_sum));
      chk({tag, "_cout"}, 32'(bus_if.c_out), 32'(exp_cout));
    end
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.a_in  = '0;
    bus_if.b_in  = '0;
    bus_if.c_in  = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_done", 32'(bus_if.done), 0);
    chk("rst_sum", 32'(bus_if.sum), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check("idle", 10);

    run_op(16'h1234, 16'h0FFF, 1'b0, 0);
    idle_check("hold1", 2);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    idle_check("hold2", 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    idle_check("hold3", 1);
    run_op(16'h0003, 16'h0008, 1'b1, 1);
    idle_check("ignored", 3);

    // Back-to-back: second request is presented in the DONE cycle.
    run_op(16'h0001, 16'h0002, 1'b0, 0);
    run_op(16'h000B, 16'h0003, 1'b0, 0);
    idle_check("b2b", 1);

    // Reset after two ADD cycles.
    bus_if.start = 1'b1;
    bus_if.a_in  = 16'h5555;
    bus_if.b_in  = 16'h1111;
    step();
    bus_if.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("amid_busy", 32'(bus_if.busy), 0);
    chk("amid_done", 32'(bus_if.done), 0);
    chk("amid_sum", 32'(bus_if.sum), 0);
    chk("amid_cout", 32'(bus_if.c_out), 0);
    $display("reset asserted mid-operation");
    exp_sum  = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check("post_rst", 6);
    run_op(16'h000F, 16'h000F, 1'b0, 0);
    idle_check("post_rst_hold", 1);

    for (int n = 0; n < 12; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check("rnd_hold", 1);
    end
    idle_check("final", 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
